// File: rtl/prt_slot_scheduler_if.sv
// Slot-scheduler bus: rx allocation, firewall verdicts, tx selection, PRT invalidates.
// alloc_req/tx_req are levels held by the requester; alloc_gnt/tx_gnt/inv_valid are one-cycle pulses.
interface prt_slot_scheduler_if #(
    parameter int NUM_SLOTS = 4,
    parameter int SLOT_W    = $clog2(NUM_SLOTS)
);
    logic                   alloc_req;
    logic                   alloc_gnt;
    logic [SLOT_W-1:0]      alloc_slot;
    logic                   rx_done;
    logic                   rx_abort;
    logic [SLOT_W-1:0]      rx_slot;
    logic                   verdict_valid;
    logic [SLOT_W-1:0]      verdict_slot;
    logic                   verdict_unsafe;
    logic                   tx_req;
    logic                   tx_gnt;
    logic [SLOT_W-1:0]      tx_slot;
    logic                   tx_active;
    logic                   tx_done;
    logic                   inv_valid;
    logic [SLOT_W-1:0]      inv_slot;
    logic                   free_slot_avail;
    logic [SLOT_W:0]        used_count;
    logic                   err;
    // Per-slot state, 3 bits each: 0 FREE, 1 RX, 2 WAIT_FW, 3 READY_TX, 4 TX.
    logic [NUM_SLOTS*3-1:0] dbg_slot_state;

    modport master (
        output alloc_req, rx_done, rx_abort, rx_slot,
        output verdict_valid, verdict_slot, verdict_unsafe, tx_req, tx_done,
        input  alloc_gnt, alloc_slot, tx_gnt, tx_slot, tx_active,
        input  inv_valid, inv_slot, free_slot_avail, used_count, err, dbg_slot_state
    );

    modport slave (
        input  alloc_req, rx_done, rx_abort, rx_slot,
        input  verdict_valid, verdict_slot, verdict_unsafe, tx_req, tx_done,
        output alloc_gnt, alloc_slot, tx_gnt, tx_slot, tx_active,
        output inv_valid, inv_slot, free_slot_avail, used_count, err, dbg_slot_state
    );
endinterface

// File: rtl/prt_slot_scheduler.sv
// PRT slot lifecycle controller: FREE -> RX -> WAIT_FW -> READY_TX -> TX -> FREE,
// arbitrating rx allocation, firewall verdicts and round-robin tx selection.
module prt_slot_scheduler #(
    parameter int NUM_SLOTS = 4,
    parameter int SLOT_W    = $clog2(NUM_SLOTS)
) (
    input  logic                clk,
    input  logic                reset,
    prt_slot_scheduler_if.slave bus
);
    typedef enum logic [2:0] {
        S_FREE     = 3'd0,
        S_RX       = 3'd1,
        S_WAIT_FW  = 3'd2,
        S_READY_TX = 3'd3,
        S_TX       = 3'd4
    } slot_state_e;

    slot_state_e       r_state     [NUM_SLOTS];
    slot_state_e       w_state_nxt [NUM_SLOTS];
    logic              r_alloc_gnt, w_alloc_gnt;
    logic [SLOT_W-1:0] r_alloc_slot, w_alloc_slot;
    logic              r_tx_gnt, w_tx_gnt;
    logic [SLOT_W-1:0] r_tx_slot, w_tx_slot;
    logic              r_tx_active, w_tx_active;
    logic              r_inv_valid, w_inv_valid;
    logic [SLOT_W-1:0] r_inv_slot, w_inv_slot;
    logic              r_free_avail, w_free_avail;
    logic [SLOT_W:0]   r_used_count, w_used_count;
    logic              r_err, w_err;
    logic [SLOT_W-1:0] r_rr_ptr, w_rr_ptr;
    logic              w_rx_ok, w_vd_ok;
    int                w_rr_idx;

    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) w_state_nxt[i] = r_state[SLOT_W'(i)];
        w_alloc_gnt  = 1'b0;
        w_alloc_slot = r_alloc_slot;
        w_tx_gnt     = 1'b0;
        w_tx_slot    = r_tx_slot;
        w_tx_active  = r_tx_active;
        w_inv_valid  = 1'b0;
        w_inv_slot   = r_inv_slot;
        w_err        = r_err;
        w_rr_ptr     = r_rr_ptr;
        w_rx_ok      = 1'b0;
        w_vd_ok      = 1'b0;
        w_rr_idx     = 0;

        // Both grants look only at start-of-cycle state, so a slot changing state
        // this cycle is never handed out in the same cycle.
        if (bus.alloc_req && !r_alloc_gnt) begin
            for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
                if (r_state[SLOT_W'(i)] == S_FREE) begin
                    w_alloc_gnt  = 1'b1;
                    w_alloc_slot = SLOT_W'(i);
                end
            end
        end

        if (bus.tx_req && !r_tx_active) begin
            for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
                w_rr_idx = int'(r_rr_ptr) + k;
                if (w_rr_idx >= NUM_SLOTS) w_rr_idx = w_rr_idx - NUM_SLOTS;
                if (r_state[SLOT_W'(w_rr_idx)] == S_READY_TX) begin
                    w_tx_gnt  = 1'b1;
                    w_tx_slot = SLOT_W'(w_rr_idx);
                end
            end
        end
        if (w_tx_gnt) begin
            w_tx_active = 1'b1;
            w_rr_ptr    = (int'(w_tx_slot) == NUM_SLOTS - 1) ? '0 : w_tx_slot + SLOT_W'(1);
        end

        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (bus.rx_slot == SLOT_W'(i) && r_state[SLOT_W'(i)] == S_RX) w_rx_ok = 1'b1;
            if (bus.verdict_slot == SLOT_W'(i) && r_state[SLOT_W'(i)] == S_WAIT_FW) w_vd_ok = 1'b1;
        end

        // rx_done and rx_abort share rx_slot, so abort simply takes priority.
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if ((bus.rx_done || bus.rx_abort) && w_rx_ok && bus.rx_slot == SLOT_W'(i))
                w_state_nxt[i] = bus.rx_abort ? S_FREE : S_WAIT_FW;
            if (bus.verdict_valid && w_vd_ok && bus.verdict_slot == SLOT_W'(i))
                w_state_nxt[i] = bus.verdict_unsafe ? S_FREE : S_READY_TX;
            if (bus.tx_done && r_tx_active && r_tx_slot == SLOT_W'(i))
                w_state_nxt[i] = S_FREE;
            if (w_alloc_gnt && w_alloc_slot == SLOT_W'(i))
                w_state_nxt[i] = S_RX;
            if (w_tx_gnt && w_tx_slot == SLOT_W'(i))
                w_state_nxt[i] = S_TX;
        end

        if ((bus.rx_done || bus.rx_abort) && !w_rx_ok) w_err = 1'b1;
        if (bus.verdict_valid && !w_vd_ok) w_err = 1'b1;
        if (bus.tx_done && !r_tx_active) w_err = 1'b1;
        if (bus.tx_done && r_tx_active) w_tx_active = 1'b0;
        if (bus.verdict_valid && w_vd_ok && bus.verdict_unsafe) begin
            w_inv_valid = 1'b1;
            w_inv_slot  = bus.verdict_slot;
        end

        w_used_count = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (w_state_nxt[i] != S_FREE) w_used_count = w_used_count + (SLOT_W+1)'(1);
        end
        w_free_avail = (w_used_count != (SLOT_W+1)'(NUM_SLOTS));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) r_state[SLOT_W'(i)] <= S_FREE;
            r_alloc_gnt  <= 1'b0;
            r_alloc_slot <= '0;
            r_tx_gnt     <= 1'b0;
            r_tx_slot    <= '0;
            r_tx_active  <= 1'b0;
            r_inv_valid  <= 1'b0;
            r_inv_slot   <= '0;
            r_free_avail <= 1'b1;
            r_used_count <= '0;
            r_err        <= 1'b0;
            r_rr_ptr     <= '0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) r_state[SLOT_W'(i)] <= w_state_nxt[i];
            r_alloc_gnt  <= w_alloc_gnt;
            r_alloc_slot <= w_alloc_slot;
            r_tx_gnt     <= w_tx_gnt;
            r_tx_slot    <= w_tx_slot;
            r_tx_active  <= w_tx_active;
            r_inv_valid  <= w_inv_valid;
            r_inv_slot   <= w_inv_slot;
            r_free_avail <= w_free_avail;
            r_used_count <= w_used_count;
            r_err        <= w_err;
            r_rr_ptr     <= w_rr_ptr;
        end
    end

    always_comb begin
        bus.dbg_slot_state = '0;
        for (int i = 0; i < NUM_SLOTS; i++) bus.dbg_slot_state[i*3 +: 3] = r_state[SLOT_W'(i)];
    end

    assign bus.alloc_gnt       = r_alloc_gnt;
    assign bus.alloc_slot      = r_alloc_slot;
    assign bus.tx_gnt          = r_tx_gnt;
    assign bus.tx_slot         = r_tx_slot;
    assign bus.tx_active       = r_tx_active;
    assign bus.inv_valid       = r_inv_valid;
    assign bus.inv_slot        = r_inv_slot;
    assign bus.free_slot_avail = r_free_avail;
    assign bus.used_count      = r_used_count;
    assign bus.err             = r_err;
endmodule
